// File: rtl/data_memory_ws.sv
// Wait-state data memory: request/done handshake, configurable latency and range fault.
// Optional byte-lane writes are enabled by defining DATA_MEMORY_WS_BYTE_STROBE_EN.
module data_memory_ws #(
  parameter int unsigned        DATA_W      = 16,
  parameter int unsigned        ADDR_W      = 16,
  parameter int unsigned        DEPTH       = 256,
  parameter int unsigned        WAIT_STATES = 2,
  parameter logic [DATA_W-1:0]  ID0         = 16'h0253,
  parameter logic [DATA_W-1:0]  ID1         = 16'h2022
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   be,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_W-1:0]     rdata,
  output logic                  fault
);

  localparam int unsigned      NumBytes = DATA_W / 8;
  localparam int unsigned      IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]       WaitCnt  = 4'(WAIT_STATES);
  localparam logic [ADDR_W:0]  DepthLim = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                fault_q;

  logic                accept, commit, direct;
  logic                c_we, in_range;
  logic [ADDR_W-1:0]   c_addr;
  logic [DATA_W-1:0]   c_wdata;
  logic [IdxW-1:0]     idx;

  // Power-up contents; reset deliberately leaves the array alone.
  logic [DATA_W-1:0]   mem_q [DEPTH] = '{0: ID0, 1: ID1, default: '0};

  assign ready  = (state_q == StIdle) || (state_q == StDone);
  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);
  assign rdata  = rdata_q;
  assign fault  = fault_q;
  assign accept = req && ready;

  // With zero wait states the commit edge is the accept edge, so use the live inputs.
  assign direct   = (WaitCnt == 4'd0);
  assign c_we     = direct ? we    : we_q;
  assign c_addr   = direct ? addr  : addr_q;
  assign c_wdata  = direct ? wdata : wdata_q;
  assign in_range = ({1'b0, c_addr} < DepthLim);
  assign idx      = c_addr[IdxW-1:0];

`ifdef DATA_MEMORY_WS_BYTE_STROBE_EN
  logic [NumBytes-1:0] be_q, c_be;
  assign c_be = direct ? be : be_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      be_q <= '0;
    end else if (accept) begin
      be_q <= be;
    end
  end
`else
  logic unused_be;
  assign unused_be = ^be;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          cnt_d = WaitCnt;
          if (direct) begin
            state_d = StDone;
            commit  = 1'b1;
          end else begin
            state_d = StWait;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = StDone;
          commit  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (commit) begin
        fault_q <= !in_range;
        if (!in_range) begin
          rdata_q <= '0;
        end else if (!c_we) begin
          rdata_q <= mem_q[idx];
        end
      end
    end
  end

  // A reset coinciding with the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && commit && c_we && in_range) begin
`ifdef DATA_MEMORY_WS_BYTE_STROBE_EN
      for (int i = 0; i < NumBytes; i++) begin
        if (c_be[i]) begin
          mem_q[idx][8*i +: 8] <= c_wdata[8*i +: 8];
        end
      end
`else
      mem_q[idx] <= c_wdata;
`endif
    end
  end

endmodule

// File: tb/tb_data_memory_ws.sv
// Scoreboard bench for data_memory_ws: one instance with two wait states, one with none.
// Expected byte-lane behaviour follows DATA_MEMORY_WS_BYTE_STROBE_EN.
module tb_data_memory_ws;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req   [2];
  logic        we    [2];
  logic [15:0] addr  [2];
  logic [15:0] wdata [2];
  logic [1:0]  be    [2];
  logic        ready [2];
  logic        busy  [2];
  logic        done  [2];
  logic        fault [2];
  logic [15:0] rdata [2];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic        chk_rd;
    logic [15:0] rdata;
    logic        fault;
    int          cyc;
  } exp_t;

  exp_t        sb0 [$];
  exp_t        sb1 [$];
  logic [15:0] mdl [2][256];
  logic [15:0] baddr [4];

  data_memory_ws #(.WAIT_STATES(2)) u_dut_ws2 (
    .clk(clk), .rst(rst), .req(req[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
    .be(be[0]), .ready(ready[0]), .busy(busy[0]), .done(done[0]), .rdata(rdata[0]),
    .fault(fault[0])
  );

  data_memory_ws #(.WAIT_STATES(0)) u_dut_ws0 (
    .clk(clk), .rst(rst), .req(req[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
    .be(be[1]), .ready(ready[1]), .busy(busy[1]), .done(done[1]), .rdata(rdata[1]),
    .fault(fault[1])
  );

  function automatic int ws_of(int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic int sb_size(int d);
    return (d == 0) ? sb0.size() : sb1.size();
  endfunction

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Completion monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (done[d] === 1'b1) begin
        if (sb_size(d) == 0) begin
          check_eq("spurious_done", {31'b0, done[d]}, 32'd0);
        end else begin
          if (d == 0) e = sb0.pop_front();
          else        e = sb1.pop_front();
          check_eq("done_cycle", cyc, e.cyc);
          check_eq("fault", {31'b0, fault[d]}, {31'b0, e.fault});
          if (e.chk_rd) check_eq("rdata", {16'b0, rdata[d]}, {16'b0, e.rdata});
        end
      end
    end
  end

  task automatic push_exp(int d, logic w, logic [15:0] a, logic [15:0] wd, logic [1:0] b);
    exp_t e;
    e.cyc    = cyc + 1 + ws_of(d);
    e.fault  = 1'b0;
    e.chk_rd = 1'b1;
    e.rdata  = '0;
    if (a >= 16'd256) begin
      e.fault = 1'b1;
    end else if (w) begin
      e.chk_rd = 1'b0;
`ifdef DATA_MEMORY_WS_BYTE_STROBE_EN
      for (int i = 0; i < 2; i++) begin
        if (b[i]) mdl[d][a[7:0]][8*i +: 8] = wd[8*i +: 8];
      end
`else
      if (b === 2'bxx) mdl[d][a[7:0]] = wd;
      else             mdl[d][a[7:0]] = wd;
`endif
    end else begin
      e.rdata = mdl[d][a[7:0]];
    end
    if (d == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  task automatic drive(int d, logic r, logic w, logic [15:0] a, logic [15:0] wd,
                       logic [1:0] b);
    req[d]   = r;
    we[d]    = w;
    addr[d]  = a;
    wdata[d] = wd;
    be[d]    = b;
  endtask

  // Junk on the inputs after accept must not disturb the access in flight.
  task automatic scramble(int d);
    drive(d, 1'b0, 1'($urandom), 16'($urandom), 16'($urandom), 2'($urandom));
  endtask

  task automatic wait_ready(int d);
    for (int k = 0; k < 50 && ready[d] !== 1'b1; k++) @(negedge clk);
    if (ready[d] !== 1'b1) check_eq("ready_timeout", {31'b0, ready[d]}, 32'd1);
  endtask

  task automatic wait_drain(int d);
    for (int k = 0; k < 60 && sb_size(d) != 0; k++) @(negedge clk);
    if (sb_size(d) != 0) check_eq("drain_timeout", sb_size(d), 32'd0);
  endtask

  task automatic do_access(int d, logic w, logic [15:0] a, logic [15:0] wd, logic [1:0] b);
    int k;
    @(negedge clk);
    wait_ready(d);
    push_exp(d, w, a, wd, b);
    drive(d, 1'b1, w, a, wd, b);
    @(negedge clk);
    scramble(d);
    for (k = 0; k < 40; k++) begin
      check_eq("busy_in_flight", {31'b0, busy[d]}, 32'd1);
      if (done[d] === 1'b1) break;
      @(negedge clk);
    end
    if (k == 40) check_eq("done_timeout", {31'b0, done[d]}, 32'd1);
    @(negedge clk);
    check_eq("busy_idle", {31'b0, busy[d]}, 32'd0);
    check_eq("ready_idle", {31'b0, ready[d]}, 32'd1);
  endtask

  // Hold req high across four reads of baddr.
  task automatic burst(int d);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      wait_ready(d);
      push_exp(d, 1'b0, baddr[k], 16'h0, 2'b11);
      drive(d, 1'b1, 1'b0, baddr[k], 16'h0, 2'b11);
      @(negedge clk);
    end
    scramble(d);
    wait_drain(d);
  endtask

  // Write on the 2-wait-state instance, then reset 'hold' cycles after the first WAIT cycle.
  task automatic reset_mid(int hold, logic [15:0] a, logic [15:0] wd);
    @(negedge clk);
    wait_ready(0);
    drive(0, 1'b1, 1'b1, a, wd, 2'b11);
    @(negedge clk);
    scramble(0);
    repeat (hold) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_ready", {31'b0, ready[0]}, 32'd1);
    check_eq("rst_busy", {31'b0, busy[0]}, 32'd0);
    check_eq("rst_rdata", {16'b0, rdata[0]}, 32'd0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      drive(d, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
      for (int i = 0; i < 256; i++) mdl[d][i] = 16'h0;
      mdl[d][0] = 16'h0253;
      mdl[d][1] = 16'h2022;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_eq("reset_ready", {31'b0, ready[d]}, 32'd1);
      check_eq("reset_busy", {31'b0, busy[d]}, 32'd0);
      check_eq("reset_done", {31'b0, done[d]}, 32'd0);
      check_eq("reset_rdata", {16'b0, rdata[d]}, 32'd0);
      check_eq("reset_fault", {31'b0, fault[d]}, 32'd0);
    end
    rst = 1'b0;

    do_access(0, 1'b0, 16'h0000, 16'h0, 2'b11);
    do_access(0, 1'b0, 16'h0001, 16'h0, 2'b11);
    do_access(0, 1'b1, 16'h0010, 16'hBEEF, 2'b11);
    do_access(0, 1'b0, 16'h0010, 16'h0, 2'b11);
    do_access(0, 1'b1, 16'h0010, 16'h1234, 2'b01);
    do_access(0, 1'b0, 16'h0010, 16'h0, 2'b11);
    do_access(0, 1'b1, 16'h0010, 16'h5555, 2'b00);
    do_access(0, 1'b0, 16'h0010, 16'h0, 2'b11);
    do_access(0, 1'b1, 16'h0100, 16'hFFFF, 2'b11);
    do_access(0, 1'b0, 16'h0000, 16'h0, 2'b11);
    do_access(0, 1'b0, 16'h8000, 16'h0, 2'b11);

    reset_mid(0, 16'h0020, 16'hAAAA);
    do_access(0, 1'b0, 16'h0020, 16'h0, 2'b11);
    reset_mid(1, 16'h0021, 16'hAAAA);
    do_access(0, 1'b0, 16'h0021, 16'h0, 2'b11);

    do_access(1, 1'b0, 16'h0001, 16'h0, 2'b11);
    do_access(1, 1'b1, 16'h0030, 16'hC0DE, 2'b11);
    do_access(1, 1'b0, 16'h0030, 16'h0, 2'b11);
    do_access(1, 1'b0, 16'hFFFF, 16'h0, 2'b11);

    baddr[0] = 16'h0000;
    baddr[1] = 16'h0001;
    baddr[2] = 16'h0010;
    baddr[3] = 16'h0200;
    burst(0);
    baddr[2] = 16'h0030;
    burst(1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
